// File: rtl/lvds_video_pkg.sv
// Shared constants and types for the LVDS video path: default panel timing,
// the RGB888 pixel record and the sync polarity.
package lvds_video_pkg;

    // Default panel raster timing (1366x768 panel)
    localparam int unsigned H_ACTIVE_DEF  = 1366;
    localparam int unsigned H_BLANK_DEF   = 50;
    localparam int unsigned V_ACTIVE_DEF  = 768;
    localparam int unsigned V_BLANK_DEF   = 12;
    localparam int unsigned HS_OFFSET_DEF = 4;
    localparam int unsigned HS_WIDTH_DEF  = 25;
    localparam int unsigned VS_OFFSET_DEF = 1;
    localparam int unsigned VS_WIDTH_DEF  = 5;

    // Level driven on hsync/vsync while the pulse is asserted
    localparam logic SYNC_ACTIVE = 1'b0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    localparam rgb888_t RGB_BLACK = '0;

endpackage

// File: rtl/lvds_delay_line.sv
// Width x Depth shift register with synchronous clear. Depth 0 is a wire.
module lvds_delay_line #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 1
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    if (Depth == 0) begin : g_pass
        assign o_q = i_d;
    end else begin : g_shift
        logic [Width-1:0] r_stage [Depth];

        // Shift one stage per clock; clear empties the whole line at once
        always_ff @(posedge i_clk) begin
            if (i_clr) begin
                for (int i = 0; i < int'(Depth); i++) begin
                    r_stage[i] <= '0;
                end
            end else begin
                r_stage[0] <= i_d;
                for (int i = 1; i < int'(Depth); i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_q = r_stage[Depth-1];
    end

endmodule

// File: rtl/lvds_pixel_fetch.sv
// Raster timing and scaled image-RAM address generator feeding video_lvds.
// Stored pixels are replicated X_SCALE columns by Y_SCALE rows; RGB and
// sync/DE leave RAM_LAT+1 cycles after the raw counter state.
module lvds_pixel_fetch
    import lvds_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
    parameter int unsigned H_BLANK   = H_BLANK_DEF,
    parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
    parameter int unsigned V_BLANK   = V_BLANK_DEF,
    parameter int unsigned HS_OFFSET = HS_OFFSET_DEF,
    parameter int unsigned HS_WIDTH  = HS_WIDTH_DEF,
    parameter int unsigned VS_OFFSET = VS_OFFSET_DEF,
    parameter int unsigned VS_WIDTH  = VS_WIDTH_DEF,
    parameter int unsigned X_SCALE   = 14,
    parameter int unsigned Y_SCALE   = 8,
    parameter int unsigned IMG_W     = 100,
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned RAM_LAT   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ene,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_rd,
    input  logic [7:0]        i_ram_r,
    input  logic [7:0]        i_ram_g,
    input  logic [7:0]        i_ram_b,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_de,
    output logic [7:0]        o_red,
    output logic [7:0]        o_green,
    output logic [7:0]        o_blue,
    output logic              o_frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;

    // +1 so that end-of-window bounds equal to the total still fit
    localparam int unsigned HW = $clog2(H_TOTAL + 1);
    localparam int unsigned VW = $clog2(V_TOTAL + 1);
    localparam int unsigned XW = $clog2(X_SCALE + 1);
    localparam int unsigned YW = $clog2(Y_SCALE + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + HS_OFFSET);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + HS_OFFSET + HS_WIDTH);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + VS_OFFSET);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + VS_OFFSET + VS_WIDTH);
    localparam logic [XW-1:0] X_LAST   = XW'(X_SCALE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(Y_SCALE - 1);
    localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] ROW_INC = ADDR_W'(IMG_W);

    // Flag bundle carried through the delay line: {ene, fs, vs_on, hs_on, act}
    localparam int unsigned FLAG_W = 5;

    logic [HW-1:0]     r_h_cnt;
    logic [VW-1:0]     r_v_cnt;
    logic [XW-1:0]     r_x_sub;
    logic [YW-1:0]     r_y_sub;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_row_base;

    logic w_line_end;
    logic w_frame_end;
    logic w_act;
    logic w_hs_on;
    logic w_vs_on;
    logic w_fs;

    logic [FLAG_W-1:0] w_flags_raw;
    logic [FLAG_W-1:0] w_flags_dly;
    logic              w_act_d;
    logic              w_hs_d;
    logic              w_vs_d;
    logic              w_fs_d;
    logic              w_ene_d;

    logic    r_de;
    logic    r_hs_on;
    logic    r_vs_on;
    logic    r_fs;
    rgb888_t r_pix;

    assign w_line_end  = (r_h_cnt == H_LAST);
    assign w_frame_end = w_line_end && (r_v_cnt == V_LAST);
    assign w_act       = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs_on     = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
    assign w_vs_on     = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);
    assign w_fs        = (r_h_cnt == '0) && (r_v_cnt == '0);

    // Raster counters: h wraps each line, v advances on line end, free-running
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_line_end) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_frame_end ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // Replication counters; col saturates so a wide line never spills rows
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x_sub    <= '0;
            r_col      <= '0;
            r_y_sub    <= '0;
            r_row_base <= '0;
        end else if (w_line_end) begin
            r_x_sub <= '0;
            r_col   <= '0;
            if (w_frame_end) begin
                r_y_sub    <= '0;
                r_row_base <= '0;
            end else if (r_v_cnt < V_ACT) begin
                if (r_y_sub == Y_LAST) begin
                    r_y_sub    <= '0;
                    r_row_base <= r_row_base + ROW_INC;
                end else begin
                    r_y_sub <= r_y_sub + 1'b1;
                end
            end
        end else if (w_act) begin
            if (r_x_sub == X_LAST) begin
                r_x_sub <= '0;
                if (r_col != COL_MAX) begin
                    r_col <= r_col + 1'b1;
                end
            end else begin
                r_x_sub <= r_x_sub + 1'b1;
            end
        end
    end

    // Address is combinational from counter state so the RAM sees it this cycle
    assign o_ram_addr = r_row_base + r_col;
    // Reset gating keeps the strobe quiet while the raster is held
    assign o_ram_rd   = w_act && i_ene && !i_rst;

    assign w_flags_raw = {i_ene, w_fs, w_vs_on, w_hs_on, w_act};

    // Align flags and ene with the RAM data; output register adds the last stage
    lvds_delay_line #(
        .Width (FLAG_W),
        .Depth (RAM_LAT)
    ) u_flag_dly (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_d   (w_flags_raw),
        .o_q   (w_flags_dly)
    );

    assign {w_ene_d, w_fs_d, w_vs_d, w_hs_d, w_act_d} = w_flags_dly;

    // Output register: RGB forced black outside active area or when disabled
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_de    <= 1'b0;
            r_hs_on <= 1'b0;
            r_vs_on <= 1'b0;
            r_fs    <= 1'b0;
            r_pix   <= RGB_BLACK;
        end else begin
            r_de    <= w_act_d;
            r_hs_on <= w_hs_d;
            r_vs_on <= w_vs_d;
            r_fs    <= w_fs_d;
            if (w_act_d && w_ene_d) begin
                r_pix <= '{r: i_ram_r, g: i_ram_g, b: i_ram_b};
            end else begin
                r_pix <= RGB_BLACK;
            end
        end
    end

    assign o_hsync       = r_hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign o_vsync       = r_vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign o_de          = r_de;
    assign o_frame_start = r_fs;
    assign o_red         = r_pix.r;
    assign o_green       = r_pix.g;
    assign o_blue        = r_pix.b;

endmodule

// File: tb/tb_lvds_pixel_fetch.sv
// Self-checking bench for lvds_pixel_fetch on a small raster, plus a second
// instance with a wide line to exercise column clamping.
module tb_lvds_pixel_fetch;

    localparam int HA = 8, HB = 4, VA = 4, VB = 2;
    localparam int HSO = 1, HSW = 2, VSO = 0, VSW = 1;
    localparam int XS = 2, YS = 2, IW = 4, AW = 14;
    localparam int HT = HA + HB, VT = VA + VB, FT = HT * VT;
    localparam int HA2 = 12, HT2 = HA2 + HB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ene = 1'b1;

    logic [AW-1:0] ram_addr, ram_addr2;
    logic          ram_rd, ram_rd2;
    logic [7:0]    ram_r = 8'd0, ram_g = 8'd0, ram_b = 8'd0;
    logic [7:0]    zero8 = 8'd0;
    logic          hsync, vsync, de, fs;
    logic [7:0]    red, green, blue;
    logic          hsync2, vsync2, de2, fs2;
    logic [7:0]    red2, green2, blue2;

    int n_checks = 0;
    int n_pass   = 0;
    int n;
    int ene_hist [0:2047];

    always #5 clk = ~clk;

    lvds_pixel_fetch #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
        .HS_OFFSET(HSO), .HS_WIDTH(HSW), .VS_OFFSET(VSO), .VS_WIDTH(VSW),
        .X_SCALE(XS), .Y_SCALE(YS), .IMG_W(IW), .ADDR_W(AW), .RAM_LAT(1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_ene(ene),
        .o_ram_addr(ram_addr), .o_ram_rd(ram_rd),
        .i_ram_r(ram_r), .i_ram_g(ram_g), .i_ram_b(ram_b),
        .o_hsync(hsync), .o_vsync(vsync), .o_de(de),
        .o_red(red), .o_green(green), .o_blue(blue), .o_frame_start(fs)
    );

    lvds_pixel_fetch #(
        .H_ACTIVE(HA2), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
        .HS_OFFSET(HSO), .HS_WIDTH(HSW), .VS_OFFSET(VSO), .VS_WIDTH(VSW),
        .X_SCALE(XS), .Y_SCALE(YS), .IMG_W(IW), .ADDR_W(AW), .RAM_LAT(1)
    ) dut_wide (
        .i_clk(clk), .i_rst(rst), .i_ene(ene),
        .o_ram_addr(ram_addr2), .o_ram_rd(ram_rd2),
        .i_ram_r(zero8), .i_ram_g(zero8), .i_ram_b(zero8),
        .o_hsync(hsync2), .o_vsync(vsync2), .o_de(de2),
        .o_red(red2), .o_green(green2), .o_blue(blue2), .o_frame_start(fs2)
    );

    // Image RAM, one cycle latency, contents derived from the address
    always @(posedge clk) begin
        if (ram_rd) begin
            ram_r <= ram_addr[7:0];
            ram_g <= ram_addr[7:0] ^ 8'h5a;
            ram_b <= ~ram_addr[7:0];
        end
    end

    // Which stored word a screen pixel shows: row = v / YS, col = h / XS clamped
    function automatic int model_addr(int h, int v, int xs, int ys, int iw);
        int col;
        col = h / xs;
        if (col > iw - 1) col = iw - 1;
        return ((v / ys) * iw + col) % (1 << AW);
    endfunction

    function automatic int model_pix(int a);
        logic [7:0] lo;
        lo = 8'(a);
        return {8'd0, lo, lo ^ 8'h5a, ~lo};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (n=%0d t=%0t)", nm, act, exp, n, $time);
    endtask

    // Start a cycle: drive ene and let combinational outputs settle
    task automatic drive(input logic e);
        ene = e;
        ene_hist[n] = int'(e);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " de"}, int'(de), 0);
        chk({tag, " hsync"}, int'(hsync), 1);
        chk({tag, " vsync"}, int'(vsync), 1);
        chk({tag, " frame_start"}, int'(fs), 0);
        chk({tag, " rgb"}, int'({red, green, blue}), 0);
        chk({tag, " ram_rd"}, int'(ram_rd), 0);
        chk({tag, " ram_addr"}, int'(ram_addr), 0);
    endtask

    // Compare every output against the raster rules applied to cycle n
    task automatic check_model();
        int m, h, v, hr, vr, h2, v2, exp_rgb;
        bit act, actr;
        m = n - 2;
        h = m % HT;
        v = (m / HT) % VT;
        act = (h < HA) && (v < VA);
        exp_rgb = (act && ene_hist[m] != 0) ? model_pix(model_addr(h, v, XS, YS, IW)) : 0;
        chk("model de", int'(de), int'(act));
        chk("model hsync", int'(hsync), (h >= HA + HSO && h < HA + HSO + HSW) ? 0 : 1);
        chk("model vsync", int'(vsync), (v >= VA + VSO && v < VA + VSO + VSW) ? 0 : 1);
        chk("model frame_start", int'(fs), (h == 0 && v == 0) ? 1 : 0);
        chk("model rgb", int'({red, green, blue}), exp_rgb);
        hr = n % HT;
        vr = (n / HT) % VT;
        actr = (hr < HA) && (vr < VA);
        chk("model ram_rd", int'(ram_rd), int'(actr && ene));
        if (actr) chk("model ram_addr", int'(ram_addr), model_addr(hr, vr, XS, YS, IW));
        h2 = n % HT2;
        v2 = (n / HT2) % VT;
        if (h2 < HA2 && v2 < VA)
            chk("wide ram_addr", int'(ram_addr2), model_addr(h2, v2, XS, YS, IW));
    endtask

    typedef struct {
        int n;
        int de;
        int hs;
        int vs;
        int fs;
        int red;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];
    int line0_exp [8];

    // Fixed first-frame timing after a reset release, ene held high
    task automatic run_table(input string tag);
        for (int c = 0; c <= 75; c++) begin
            drive(1'b1);
            for (int k = 0; k < NV; k++) begin
                if (tbl[k].n == n) begin
                    chk($sformatf("%s tbl[%0d] de", tag, k), int'(de), tbl[k].de);
                    chk($sformatf("%s tbl[%0d] hsync", tag, k), int'(hsync), tbl[k].hs);
                    chk($sformatf("%s tbl[%0d] vsync", tag, k), int'(vsync), tbl[k].vs);
                    chk($sformatf("%s tbl[%0d] fs", tag, k), int'(fs), tbl[k].fs);
                    chk($sformatf("%s tbl[%0d] red", tag, k), int'(red), tbl[k].red);
                end
            end
            if (n < 8) chk($sformatf("%s line0 addr[%0d]", tag, n), int'(ram_addr), line0_exp[n]);
            if (n >= 12 && n < 20)
                chk($sformatf("%s line1 addr[%0d]", tag, n - 12), int'(ram_addr), line0_exp[n - 12]);
            if (n >= 24 && n < 32)
                chk($sformatf("%s line2 addr[%0d]", tag, n - 24), int'(ram_addr),
                    line0_exp[n - 24] + 4);
            step();
        end
    endtask

    initial begin
        int drop_exp [5];
        line0_exp = '{0, 0, 1, 1, 2, 2, 3, 3};
        drop_exp  = '{4, 0, 0, 0, 6};
        //          n   de hs vs fs red
        tbl[0]  = '{0,  0, 1, 1, 0, 0};
        tbl[1]  = '{1,  0, 1, 1, 0, 0};
        tbl[2]  = '{2,  1, 1, 1, 1, 0};
        tbl[3]  = '{3,  1, 1, 1, 0, 0};
        tbl[4]  = '{4,  1, 1, 1, 0, 1};
        tbl[5]  = '{9,  1, 1, 1, 0, 3};
        tbl[6]  = '{10, 0, 1, 1, 0, 0};
        tbl[7]  = '{11, 0, 0, 1, 0, 0};
        tbl[8]  = '{12, 0, 0, 1, 0, 0};
        tbl[9]  = '{13, 0, 1, 1, 0, 0};
        tbl[10] = '{14, 1, 1, 1, 0, 0};
        tbl[11] = '{29, 1, 1, 1, 0, 5};
        tbl[12] = '{45, 1, 1, 1, 0, 7};
        tbl[13] = '{50, 0, 1, 0, 0, 0};
        tbl[14] = '{59, 0, 0, 0, 0, 0};
        tbl[15] = '{61, 0, 1, 0, 0, 0};
        tbl[16] = '{62, 0, 1, 1, 0, 0};
        tbl[17] = '{74, 1, 1, 1, 1, 0};
        tbl[18] = '{8,  1, 1, 1, 0, 3};

        n = 0;
        rst = 1'b1;
        ene = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset($sformatf("reset[%0d]", i));
        end
        rst = 1'b0;
        n = 0;
        run_table("first");

        // ene dropped for raw pixels h=2..4 of line 2 in the next frame
        while ((n % FT) != 2 * HT + 1) begin
            drive(1'b1);
            step();
        end
        for (int c = 0; c < 8; c++) begin
            drive((c >= 1 && c <= 3) ? 1'b0 : 1'b1);
            if (c >= 2 && c <= 6) begin
                chk($sformatf("ene drop red[%0d]", c - 2), int'(red), drop_exp[c - 2]);
                chk($sformatf("ene drop de[%0d]", c - 2), int'(de), 1);
            end
            step();
        end

        // Random ene against the reference model
        for (int c = 0; c < 300; c++) begin
            drive(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            check_model();
            step();
        end

        // Reset asserted at raw pixel (5,2)
        while ((n % FT) != 2 * HT + 5) begin
            drive(1'b1);
            step();
        end
        rst = 1'b1;
        drive(1'b1);
        chk("mid reset ram_rd", int'(ram_rd), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset($sformatf("mid reset[%0d]", i));
        end
        rst = 1'b0;
        n = 0;
        run_table("restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
